// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: state encodings, port ids and size constants shared by
// the data-memory arbiter and its round-robin picker.
package dmem_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam logic [1:0] SIZE_WORD = 2'b11;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-requester round-robin picker; on a tie the
// port that did not win last time is chosen.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic rr_last_i,
    output logic valid_o,
    output logic winner_o
);

    assign valid_o  = req0_i | req1_i;
    assign winner_o = (req0_i & req1_i) ? ~rr_last_i : (req1_i ? PORT_LOADER : PORT_CPU);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_memory port between the CPU load/store
// path (port 0) and the loader/debug path (port 1), one transaction at a time.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_size,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_size,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              re_q, re_d;
    logic              wstb_q, wstb_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              grant_valid;
    logic              grant;

    rr_arbiter2 u_rr (
        .req0_i   (p0_req),
        .req1_i   (p1_req),
        .rr_last_i(rr_last_q),
        .valid_o  (grant_valid),
        .winner_o (grant)
    );

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        re_d      = 1'b0;
        wstb_d    = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    win_d     = grant;
                    rr_last_d = grant;
                    we_d      = grant ? p1_we : p0_we;
                    addr_d    = grant ? p1_addr : p0_addr;
                    size_d    = grant ? p1_size : p0_size;
                    wdata_d   = we_d ? (grant ? p1_wdata : p0_wdata) : '0;
                    re_d      = ~we_d;
                    wstb_d    = we_d;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 3'(READ_LATENCY - 1);
                ack0_d  = we_q & (win_q == PORT_CPU);
                ack1_d  = we_q & (win_q == PORT_LOADER);
                state_d = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 3'd1;
                if (cnt_q == '0) begin
                    ack0_d   = win_q == PORT_CPU;
                    ack1_d   = win_q == PORT_LOADER;
                    rdata0_d = (win_q == PORT_CPU) ? mem_rdata : rdata0_q;
                    rdata1_d = (win_q == PORT_LOADER) ? mem_rdata : rdata1_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rr_last resets to the loader so the CPU wins the first tie
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_last_q <= PORT_LOADER;
            win_q     <= PORT_CPU;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            cnt_q     <= '0;
            re_q      <= 1'b0;
            wstb_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            re_q      <= re_d;
            wstb_q    <= wstb_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign p0_ack    = ack0_q;
    assign p1_ack    = ack1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign mem_re    = re_q;
    assign mem_we    = wstb_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives two arbiters (read latency 1 and 3) from shared
// requesters and checks them against word memories and a round-robin model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } bus_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic [1:0]  p0_size = '0, p1_size = '0;

    logic        a_p0_ack, a_p1_ack, a_mem_re, a_mem_we;
    logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [1:0]  a_mem_size;
    logic        b_p0_ack, b_p1_ack, b_mem_re, b_mem_we;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_mem_size;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] b_s0, b_s1;
    logic [31:0] exp_mem [logic [31:0]];
    bus_t        bus_q [$];
    int          cyc = 0, dual_a = 0, dual_b = 0;
    int          n_tests = 0, n_fail = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) u_dut_a (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size),
        .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size),
        .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_re(a_mem_re), .mem_we(a_mem_we),
        .mem_size(a_mem_size), .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) u_dut_b (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .mem_size(b_mem_size), .mem_rdata(b_mem_rdata)
    );

    // Word memories; read data is garbage except in the cycle(s) the latency defines
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cyc == 0) for (int i = 0; i < 1024; i++) begin mem_a[i] <= '0; mem_b[i] <= '0; end
        if (a_mem_we) mem_a[a_mem_addr[11:2]] <= a_mem_wdata;
        if (b_mem_we) mem_b[b_mem_addr[11:2]] <= b_mem_wdata;
        a_mem_rdata <= a_mem_re ? mem_a[a_mem_addr[11:2]] : (32'hBAD0_0000 ^ 32'(cyc));
        b_s0 <= b_mem_re ? mem_b[b_mem_addr[11:2]] : (32'hBAD1_0000 ^ 32'(cyc));
        b_s1 <= b_s0;
        b_mem_rdata <= b_s1;
        if (a_mem_re || a_mem_we) bus_q.push_back({a_mem_we, a_mem_addr, a_mem_wdata, a_mem_size});
        if (a_p0_ack && a_p1_ack) dual_a <= dual_a + 1;
        if (b_p0_ack && b_p1_ack) dual_b <= dual_b + 1;
    end

    function automatic logic [31:0] expv(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_size = size;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_size = size;
    endtask

    task automatic test_reset();
        int t;
        drive0(1'b1, 1'b1, 32'h1000_0040, 32'h0A0A_0A0A, SIZE_WORD);
        drive1(1'b1, 1'b1, 32'h1000_0044, 32'h1B1B_1B1B, SIZE_WORD);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({a_p0_ack, a_p1_ack, a_mem_re, a_mem_we, b_p0_ack, b_p1_ack, b_mem_re, b_mem_we} !== 8'h00 ||
                a_p0_rdata !== 32'h0 || a_p1_rdata !== 32'h0 || b_p0_rdata !== 32'h0 || b_p1_rdata !== 32'h0 ||
                a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0 || a_mem_size !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: ack/strobe bits=%b rdata=%h/%h addr=%h wdata=%h, required all zero",
                         i, {a_p0_ack, a_p1_ack, a_mem_re, a_mem_we, b_p0_ack, b_p1_ack, b_mem_re, b_mem_we},
                         a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata);
            end
        end
        reset = 1'b1;
        t = 0;
        while (!a_p0_ack && !a_p1_ack && t < 10) begin tick(); t++; end
        n_tests++;
        if (a_p0_ack !== 1'b1 || a_p1_ack !== 1'b0 || t !== 2) begin
            n_fail++;
            $display("FAIL first_grant: p0_ack=%b p1_ack=%b after %0d cycles, required p0 ack after 2", a_p0_ack, a_p1_ack, t);
        end
        exp_mem[32'h1000_0040] = 32'h0A0A_0A0A;
        p0_req = 1'b0;
        t = 0;
        while (!a_p1_ack && t < 10) begin tick(); t++; end
        n_tests++;
        if (a_p1_ack !== 1'b1 || a_p0_ack !== 1'b0 || t !== 2) begin
            n_fail++;
            $display("FAIL second_grant: p1_ack=%b p0_ack=%b after %0d cycles, required p1 ack after 2", a_p1_ack, a_p0_ack, t);
        end
        exp_mem[32'h1000_0044] = 32'h1B1B_1B1B;
        p1_req = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        bus_q.delete();
        drive0(1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 2'd3);
        tick();
        n_tests++;
        if (a_mem_we !== 1'b1 || a_mem_re !== 1'b0 || a_mem_addr !== 32'h1000_0010 ||
            a_mem_wdata !== 32'hDEAD_BEEF || a_mem_size !== 2'd3 || a_p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_issue: we=%b re=%b addr=%h wdata=%h size=%0d ack=%b, required 1 0 10000010 deadbeef 3 0",
                     a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata, a_mem_size, a_p0_ack);
        end
        tick();
        n_tests++;
        if (a_p0_ack !== 1'b1 || a_p1_ack !== 1'b0 || a_mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack: p0_ack=%b p1_ack=%b mem_we=%b, required 1 0 0", a_p0_ack, a_p1_ack, a_mem_we);
        end
        p0_req = 1'b0;
        tick();
        n_tests++;
        if (a_p0_ack !== 1'b0 || bus_q.size() != 1) begin
            n_fail++;
            $display("FAIL wr_single_pulse: p0_ack=%b accesses=%0d, required 0 and 1", a_p0_ack, bus_q.size());
        end
        exp_mem[32'h1000_0010] = 32'hDEAD_BEEF;
    endtask

    task automatic test_single_read();
        logic [31:0] old0;
        old0 = a_p0_rdata;
        drive1(1'b1, 1'b0, 32'h1000_0010, 32'h5555_5555, SIZE_WORD);
        tick();
        n_tests++;
        if (a_mem_re !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 32'h1000_0010 || a_mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_issue: re=%b we=%b addr=%h wdata=%h, required 1 0 10000010 0", a_mem_re, a_mem_we, a_mem_addr, a_mem_wdata);
        end
        tick();
        n_tests++;
        if (a_p1_ack !== 1'b0 || a_mem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wait: p1_ack=%b re=%b, required 0 0", a_p1_ack, a_mem_re);
        end
        tick();
        n_tests++;
        if (a_p1_ack !== 1'b1 || a_p1_rdata !== expv(32'h1000_0010) || a_p0_ack !== 1'b0 || a_p0_rdata !== old0) begin
            n_fail++;
            $display("FAIL rd_ack: p1_ack=%b p1_rdata=%h p0_rdata=%h, required 1 %h %h",
                     a_p1_ack, a_p1_rdata, a_p0_rdata, expv(32'h1000_0010), old0);
        end
        p1_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] addr0 [4];
        logic [31:0] data0 [4];
        int exp_order [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int n0 = 0, n1 = 0, g = 0, t = 0, d0, got;
        for (int k = 0; k < 4; k++) begin addr0[k] = 32'h1000_0100 + 32'(4 * k); data0[k] = $urandom; end
        d0 = dual_a;
        drive0(1'b1, 1'b1, addr0[0], data0[0], SIZE_WORD);
        drive1(1'b1, 1'b0, addr0[0], 32'h0, SIZE_WORD);
        while ((n0 < 4 || n1 < 4) && t < 100) begin
            tick();
            t++;
            if (a_p0_ack || a_p1_ack) begin
                got = a_p1_ack ? 1 : 0;
                n_tests++;
                if (g >= 8 || got !== exp_order[g] || (a_p1_ack && a_p1_rdata !== expv(addr0[n1]))) begin
                    n_fail++;
                    $display("FAIL grant_order #%0d: port %0d rdata=%h, required port %0d rdata=%h",
                             g, got, a_p1_rdata, (g < 8) ? exp_order[g] : -1, expv(addr0[n1]));
                end
                g++;
            end
            if (a_p0_ack) begin
                exp_mem[addr0[n0]] = data0[n0];
                n0++;
                if (n0 < 4) drive0(1'b1, 1'b1, addr0[n0], data0[n0], SIZE_WORD); else p0_req = 1'b0;
            end
            if (a_p1_ack) begin
                n1++;
                if (n1 < 4) drive1(1'b1, 1'b0, addr0[n1], 32'h0, SIZE_WORD); else p1_req = 1'b0;
            end
        end
        n_tests++;
        if (n0 != 4 || n1 != 4 || dual_a != d0) begin
            n_fail++;
            $display("FAIL contention_done: acks p0=%0d p1=%0d dual=%0d, required 4 4 0", n0, n1, dual_a - d0);
        end
        tick();
    endtask

    task automatic test_withdrawn();
        bus_q.delete();
        drive0(1'b1, 1'b1, 32'h1000_0020, 32'h1234_5678, SIZE_WORD);
        tick();
        drive0(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 2'd0);
        n_tests++;
        if (a_mem_we !== 1'b1 || a_mem_addr !== 32'h1000_0020 || a_mem_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL withdraw_issue: we=%b addr=%h wdata=%h, required 1 10000020 12345678", a_mem_we, a_mem_addr, a_mem_wdata);
        end
        tick();
        n_tests++;
        if (a_p0_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_ack: p0_ack=%b, required 1", a_p0_ack);
        end
        tick();
        tick();
        n_tests++;
        if (a_p0_ack !== 1'b0 || bus_q.size() != 1) begin
            n_fail++;
            $display("FAIL withdraw_once: p0_ack=%b accesses=%0d, required 0 and 1", a_p0_ack, bus_q.size());
        end
        exp_mem[32'h1000_0020] = 32'h1234_5678;
    endtask

    task automatic test_reset_mid_read();
        int t;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        drive0(1'b1, 1'b1, 32'h3000_0000, 32'hCAFE_F00D, SIZE_WORD);
        tick();
        tick();
        n_tests++;
        if (b_p0_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL rl3_setup_write: p0_ack=%b, required 1", b_p0_ack);
        end
        exp_mem[32'h3000_0000] = 32'hCAFE_F00D;
        drive0(1'b1, 1'b0, 32'h3000_0000, 32'h0, SIZE_WORD);
        tick();
        p0_req = 1'b0;
        t = 1;
        while (!b_p0_ack && t < 12) begin tick(); t++; end
        n_tests++;
        if (b_p0_ack !== 1'b1 || t !== 5 || b_p0_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL rl3_read: ack=%b after %0d cycles rdata=%h, required ack after 5 rdata=cafef00d", b_p0_ack, t, b_p0_rdata);
        end
        drive0(1'b1, 1'b0, 32'h3000_0000, 32'h0, SIZE_WORD);
        tick();
        p0_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (b_p0_ack !== 1'b0 || b_p1_ack !== 1'b0 || b_mem_re !== 1'b0 || b_p0_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL mid_read_abort cyc%0d: p0_ack=%b p1_ack=%b re=%b p0_rdata=%h, required 0 0 0 0",
                         i, b_p0_ack, b_p1_ack, b_mem_re, b_p0_rdata);
            end
            tick();
        end
        drive1(1'b1, 1'b1, 32'h3000_0004, 32'h7777_0001, SIZE_WORD);
        tick();
        tick();
        n_tests++;
        if (b_p1_ack !== 1'b1 || b_p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: p1_ack=%b p0_ack=%b, required 1 0", b_p1_ack, b_p0_ack);
        end
        exp_mem[32'h3000_0004] = 32'h7777_0001;
        p1_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bus_t tr [2];
        bus_t e;
        bit   pend [2];
        int   age [2];
        int   t = 0;
        logic ack;
        logic [31:0] rd, wd;
        bus_q.delete();
        pend = '{1'b0, 1'b0};
        age  = '{0, 0};
        while ((t < 400 || pend[0] || pend[1]) && t < 600) begin
            tick();
            t++;
            for (int p = 0; p < 2; p++) begin
                ack = (p != 0) ? a_p1_ack : a_p0_ack;
                rd  = (p != 0) ? a_p1_rdata : a_p0_rdata;
                if (ack) begin
                    e = '0;
                    if (bus_q.size() > 0) e = bus_q.pop_front();
                    n_tests++;
                    if (!pend[p] || e !== tr[p] || (!tr[p].we && rd !== expv(tr[p].addr))) begin
                        n_fail++;
                        $display("FAIL rand_ack p%0d t%0d: pending=%0d bus=%h rdata=%h, required bus=%h rdata=%h",
                                 p, t, pend[p], e, rd, tr[p], expv(tr[p].addr));
                    end
                    if (pend[p] && tr[p].we) exp_mem[tr[p].addr] = tr[p].wdata;
                    pend[p] = 1'b0;
                end else if (pend[p] && ++age[p] > 8) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand_starve p%0d t%0d: no ack after %0d cycles, required within 8", p, t, age[p]);
                    pend[p] = 1'b0;
                end
                if (!pend[p] && t < 400 && $urandom_range(0, 1) == 1) begin
                    tr[p].we    = 1'($urandom_range(0, 1));
                    tr[p].addr  = 32'h2000_0200 + 32'(4 * $urandom_range(0, 15));
                    tr[p].size  = 2'($urandom_range(0, 3));
                    wd          = $urandom;
                    tr[p].wdata = tr[p].we ? wd : 32'h0;
                    pend[p]     = 1'b1;
                    age[p]      = 0;
                    if (p == 0) drive0(1'b1, tr[p].we, tr[p].addr, wd, tr[p].size);
                    else drive1(1'b1, tr[p].we, tr[p].addr, wd, tr[p].size);
                end else if (!pend[p]) begin
                    if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
                end
            end
        end
        n_tests++;
        if (pend[0] || pend[1] || bus_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: pending=%0d/%0d leftover accesses=%0d, required none", pend[0], pend[1], bus_q.size());
        end
    endtask

    task automatic test_no_dual_ack();
        n_tests++;
        if (dual_a != 0 || dual_b != 0) begin
            n_fail++;
            $display("FAIL dual_ack: cycles with both acks a=%0d b=%0d, required 0", dual_a, dual_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_withdrawn();
        test_reset_mid_read();
        test_random();
        test_no_dual_ack();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory port between two requesters: port 0 is the processor load/store path, and port 1 is a loader/debug path that preloads or inspects data memory.
- Sits between the requesters and data_memory's addr_in/writedata_in/re_in/we_in/size_in/readdata_out.
- Registers each winning request, issues exactly one memory access, and returns a one-cycle ack (plus read data) to the winner.
- Round-robin arbitration, so neither port starves.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- READ_LATENCY, 1, cycles from mem_re to valid mem_rdata (1..7).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clock).
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_size  in  2  port 0 access size (same encoding as data_memory size_in).
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_rdata  out  DATA_W  port 0 read data; valid when p0_ack is high and the access was a read.
- p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_ack, p1_rdata: identical for port 1.
- mem_addr  out  ADDR_W  to data_memory addr_in.
- mem_wdata  out  DATA_W  to data_memory writedata_in.
- mem_re  out  1  to data_memory re_in.
- mem_we  out  1  to data_memory we_in.
- mem_size  out  2  to data_memory size_in.
- mem_rdata  in  DATA_W  from data_memory readdata_out.

Behaviour:
- Reset (reset == 0 at the clock edge):
  - state = IDLE; rr_last = 1, so port 0 wins the first tie.
  - All acks, mem_re and mem_we = 0; mem_addr, mem_wdata and mem_size = 0.
  - p0_rdata and p1_rdata = 0; wait counter = 0.
  - Reset mid-transaction aborts it: no ack is issued and any pending read data is discarded.
- State machine (all outputs registered):
  - IDLE:
    - If neither req is high, stay in IDLE.
    - If exactly one req is high, that port wins.
    - If both are high, the winner is the port other than rr_last.
    - On a win: latch the winner's addr, wdata, size and we into mem_* holding registers; record the winner id; set rr_last = winner; go to ISSUE.
  - ISSUE (exactly 1 cycle): mem_re = ~we and mem_we = we, driven from the latched values.
    - Write: pulse the winner's ack in the next cycle; next state IDLE.
    - Read: load wait counter = READ_LATENCY - 1; next state WAIT.
  - WAIT:
    - mem_re = 0; mem_addr and mem_size stay held.
    - Decrement the counter each cycle.
    - When the counter is 0: capture mem_rdata into the winner's pN_rdata and pulse pN_ack the same cycle; next state IDLE.
- Latency (IDLE sample to ack):
  - Write: 2 cycles.
  - Read: 2 + READ_LATENCY cycles.
- One transaction in flight at a time. A new arbitration decision happens only in IDLE; the ack cycle is spent in IDLE and may arbitrate again in that same cycle.
- A requester that drops req after being latched still receives its ack. Its transaction completes and is not cancelled.
- The losing port's req stays pending with no ack. Under continuous requests from both ports, grants strictly alternate 0,1,0,1.
- An ack is never asserted on both ports in the same cycle.
- pN_rdata holds its last value until the next read completes for that port. Writes do not modify it.
- Inputs of a non-winning port are ignored. Inputs of the winner are ignored after latching.
- Address, size and data are passed through unmodified: no alignment check, no address decode. Serial-mapped addresses behave exactly as data_memory defines.
- mem_wdata = 0 during reads. All mem_* strobes are 0 in IDLE and WAIT.

Decomposition:
- Shared package:
  - State encoding constants: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2.
  - Port id constants: PORT_CPU = 1'b0, PORT_LOADER = 1'b1.
  - Access size constant for word access: 2'b11.
- One natural sub-module, rr_arbiter2: a two-requester round-robin picker with an rr_last input and winner/valid outputs. It is purely combinational; rr_last is owned by dmem_arbiter.

Test Plan:
- Reset held low 3 cycles with both reqs high: all acks, mem_re and mem_we = 0 and rdata = 0 throughout. The first grant after release goes to port 0.
- Single write: p0 req, we = 1, addr = 0x1000_0010, wdata = 0xDEAD_BEEF, size = 3. Required:
  - mem_we high exactly 1 cycle with those values;
  - p0_ack 2 cycles after req is sampled;
  - p1_ack stays 0.
- Single read, READ_LATENCY = 1: p1 reads 0x1000_0010 and the memory model returns 0xDEAD_BEEF. Required: p1_ack and p1_rdata = 0xDEAD_BEEF 3 cycles after sampling; p0_rdata unchanged.
- Contention: both ports hold req for 4 transactions each (p0 writes, p1 reads). Required: grant order 0,1,0,1,0,1,0,1 and never two acks in one cycle.
- Withdrawn request: p0 drops req the cycle after IDLE latches it. Required: the write still occurs and p0_ack still pulses once.
- Reset mid-read with READ_LATENCY = 3: reset goes low during WAIT. Required: no ack is issued, state returns to IDLE, and pN_rdata = 0.
